// File: rtl/logic_pkg.sv
// Shared definitions for the logic-op pipe: default width, opcodes, command layout.
package logic_pkg;

    localparam int unsigned LOGIC_WIDTH = 64;

    // Opcode encoding understood by logic_unit
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // Packed command as stored in the FIFO: {a, b, sel}
    localparam int unsigned CMD_W = 2 * LOGIC_WIDTH + 3;

    typedef struct packed {
        logic [LOGIC_WIDTH-1:0] a;
        logic [LOGIC_WIDTH-1:0] b;
        logic [2:0]             sel;
    } cmd_t;

endpackage

// File: rtl/logic_cmd_fifo.sv
// Synchronous command FIFO; full/empty are decided from the occupancy count.
module logic_cmd_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [PTR_W:0]    count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;

    // Pointer and occupancy next state; pointers wrap naturally (DEPTH is a power of two)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below count, so no reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/logic_unit.sv
// Combinational bitwise logic unit selected by a 3-bit opcode.
module logic_unit
    import logic_pkg::*;
#(
    parameter int unsigned WIDTH = LOGIC_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] y
);

    // Opcode decode
    always_comb begin
        y = '0;
        unique case (sel)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            OP_NAND: y = ~(a & b);
            OP_XNOR: y = ~(a ^ b);
            OP_NOTA: y = ~a;
            OP_PASS: y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_pipe.sv
// Buffered issue/result stage around logic_unit with valid/ready on both sides.
module logic_op_pipe
    import logic_pkg::*;
#(
    parameter int unsigned WIDTH = LOGIC_WIDTH,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_sel,
    output logic             out_zero,
    output logic [PTR_W:0]   fifo_count
);

    // Same {a, b, sel} layout as cmd_t, sized from WIDTH
    localparam int unsigned CmdW = 2 * WIDTH + 3;

    logic [CmdW-1:0]  head_cmd;
    logic [WIDTH-1:0] head_a, head_b, head_res;
    logic [2:0]       head_sel;
    logic             push, pop;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [2:0]       out_sel_q, out_sel_d;
    logic             out_zero_q, out_zero_d;

    // No look-ahead at a same-cycle pop: a full FIFO always refuses
    assign in_ready = (fifo_count != (PTR_W + 1)'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (fifo_count != '0) && (!out_valid_q || out_ready);

    logic_cmd_fifo #(
        .DATA_W (CmdW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({in_a, in_b, in_sel}),
        .pop   (pop),
        .rdata (head_cmd),
        .count (fifo_count)
    );

    assign {head_a, head_b, head_sel} = head_cmd;

    logic_unit #(
        .WIDTH (WIDTH)
    ) u_logic_unit (
        .a   (head_a),
        .b   (head_b),
        .sel (head_sel),
        .y   (head_res)
    );

    // Result register next state: load on pop, otherwise clear valid once consumed
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_zero_d  = out_zero_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = head_res;
            out_sel_d   = head_sel;
            out_zero_d  = (head_res == '0);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard bench for logic_op_pipe: stimulus queues expected results, monitor checks outputs.
module tb_logic_op_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a, in_b;
    logic [2:0]  in_sel;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [2:0]  out_sel;
    logic        out_zero;
    logic [2:0]  fifo_count;

    int n_vec = 0;
    int n_err = 0;
    int pop_cnt = 0;
    logic [66:0] sb[$];   // {sel, expected data}

    localparam logic [63:0] A5 = 64'hA5A5A5A5A5A5A5A5;
    localparam logic [63:0] X5 = 64'h5A5A5A5A5A5A5A5A;
    localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;

    logic_op_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sel    (out_sel),
        .out_zero   (out_zero),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one command and hold it until accepted; expected result is queued on acceptance
    task automatic push_cmd(input logic [63:0] a, input logic [63:0] b, input logic [2:0] s,
                            input logic [63:0] e);
        int w = 0;
        in_a = a; in_b = b; in_sel = s; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL push_timeout: in_ready stuck at 0 expected 1");
        end else begin
            sb.push_back({s, e});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int w = 0;
        while ((sb.size() != 0 || out_valid) && w < 200) begin
            tick(1);
            w++;
        end
        chk({name, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: a transfer happens at the next edge whenever valid and ready are seen here
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [66:0] e;
            pop_cnt++;
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_result: got %h expected none", out_data);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_data, e[63:0]);
                chk("out_sel", 64'(out_sel), 64'(e[66:64]));
                chk("out_zero", 64'(out_zero), 64'(e[63:0] == 64'd0));
            end
        end
    end

    initial begin
        logic [63:0] stream_exp [8];
        logic [63:0] held;
        int pc0;
        stream_exp = '{64'd0, ONES, ONES, 64'd0, ONES, 64'd0, X5, A5};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sel = '0;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_sel", 64'(out_sel), 64'd0);
        chk("rst_out_zero", 64'(out_zero), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        #5 rst_n = 1'b1;
        tick(1);

        // Single op latency
        out_ready = 1'b1;
        push_cmd(64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F, 3'b000, 64'h0F000F000F000F00);
        chk("lat_valid_k", 64'(out_valid), 64'd0);
        tick(1);
        chk("lat_valid_k1", 64'(out_valid), 64'd1);
        chk("lat_data_k1", out_data, 64'h0F000F000F000F00);
        drain("single");

        // Back-to-back stream over all opcodes
        pc0 = pop_cnt;
        for (int i = 0; i < 8; i++) push_cmd(A5, X5, 3'(i), stream_exp[i]);
        tick(2);
        chk("stream_rate", 64'(pop_cnt - pc0), 64'd8);
        drain("stream");

        // Backpressure to full
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(64'(i + 1), ONES, 3'b111, 64'(i + 1));
        chk("bp_count", 64'(fifo_count), 64'd4);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_data", out_data, 64'd1);
        in_a = 64'd6; in_b = ONES; in_sel = 3'b111; in_valid = 1'b1;
        tick(3);
        chk("bp_hold_count", 64'(fifo_count), 64'd4);
        chk("bp_hold_data", out_data, 64'd1);
        chk("bp_hold_sel", 64'(out_sel), 64'd7);
        out_ready = 1'b1;
        push_cmd(64'd6, ONES, 3'b111, 64'd6);
        drain("bp");

        // Simultaneous push and pop at occupancy 2
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd(64'(16 + i), 64'hF0, 3'b000, 64'((16 + i) & 8'hF0));
        chk("pp_start_count", 64'(fifo_count), 64'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_cmd(64'(i * 3), 64'h1, 3'b010, 64'(i * 3) ^ 64'h1);
            chk("pp_count", 64'(fifo_count), 64'd2);
        end
        drain("pp");

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(64'hDEAD0000 + 64'(i), 64'd0, 3'b001,
                                             64'hDEAD0000 + 64'(i));
        chk("pre_rst_count", 64'(fifo_count), 64'd3);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_count", 64'(fifo_count), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        #7 rst_n = 1'b1;
        tick(1);
        out_ready = 1'b1;
        push_cmd(64'h1234, 64'h00FF, 3'b101, ~(64'h1234 ^ 64'h00FF));
        drain("post_rst");

        // Idle inputs are don't-care
        out_ready = 1'b0;
        push_cmd(64'h77, 64'h0, 3'b011, ~64'h77);
        push_cmd(64'h0, 64'h0, 3'b100, ONES);
        held = out_data;
        chk("idle_start_count", 64'(fifo_count), 64'd1);
        for (int i = 0; i < 10; i++) begin
            in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_sel = 3'($urandom);
            tick(1);
        end
        chk("idle_count", 64'(fifo_count), 64'd1);
        chk("idle_valid", 64'(out_valid), 64'd1);
        chk("idle_data", out_data, held);
        chk("idle_data_exp", out_data, ~64'h77);
        out_ready = 1'b1;
        drain("idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
